// File: rtl/seq_ctrl.sv
// Multi-cycle sequencer for the accumulator core: FETCH/DECODE/MEM/EXEC stepping,
// memory handshake with timeout guard, illegal-opcode trap and retire counter.
module seq_ctrl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic [3:0]       opc,
    input  logic             dec_jump,
    input  logic             dec_branch,
    input  logic             dec_memread,
    input  logic             dec_memwrite,
    input  logic             dec_accwrite,
    input  logic             acc_zero,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_we,
    output logic             addr_sel,
    output logic             ir_we,
    output logic             mdr_we,
    output logic             pc_we,
    output logic             pc_src,
    output logic             acc_we,
    output logic [2:0]       state,
    output logic             halted,
    output logic [1:0]       err,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_MEM    = 3'd3,
        S_EXEC   = 3'd4,
        S_HALT   = 3'd5
    } state_e;

    localparam int             WCW  = $clog2(MEM_TIMEOUT) + 1;
    localparam logic [WCW-1:0] WLIM = WCW'(MEM_TIMEOUT - 1);

    state_e           state_q, state_d;
    logic [WCW-1:0]   wcnt_q, wcnt_d;
    logic [1:0]       err_q, err_d;
    logic [CNT_W-1:0] ret_q, ret_d;
    logic             jmp_q, jmp_d;
    logic             br_q, br_d;
    logic             rd_q, rd_d;
    logic             wr_q, wr_d;
    logic             accw_q, accw_d;
    logic             illegal;
    logic             retire;
    logic             timeout;

    assign illegal = (opc == 4'b0110) || (opc == 4'b0111) || (opc == 4'b1101);
    assign timeout = !mem_ready && (wcnt_q == WLIM);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            wcnt_q  <= '0;
            err_q   <= 2'b00;
            ret_q   <= '0;
            jmp_q   <= 1'b0;
            br_q    <= 1'b0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            accw_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            err_q   <= err_d;
            ret_q   <= ret_d;
            jmp_q   <= jmp_d;
            br_q    <= br_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            accw_q  <= accw_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        wcnt_d   = '0;
        err_d    = err_q;
        ret_d    = ret_q;
        jmp_d    = jmp_q;
        br_d     = br_q;
        rd_d     = rd_q;
        wr_d     = wr_q;
        accw_d   = accw_q;
        retire   = 1'b0;
        mem_req  = 1'b0;
        mem_we   = 1'b0;
        addr_sel = 1'b0;
        ir_we    = 1'b0;
        mdr_we   = 1'b0;
        pc_we    = 1'b0;
        pc_src   = 1'b0;
        acc_we   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (run) state_d = S_FETCH;
            end
            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_we   = 1'b1;
                    pc_we   = 1'b1;
                    state_d = S_DECODE;
                end else if (timeout) begin
                    err_d   = 2'b01;
                    state_d = S_HALT;
                end else begin
                    wcnt_d = wcnt_q + WCW'(1);
                end
            end
            S_DECODE: begin
                jmp_d  = dec_jump;
                br_d   = dec_branch;
                rd_d   = dec_memread;
                wr_d   = dec_memwrite;
                accw_d = dec_accwrite;
                if (illegal) begin
                    err_d   = 2'b10;
                    state_d = S_HALT;
                end else if (dec_memread || dec_memwrite) begin
                    state_d = S_MEM;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_MEM: begin
                mem_req  = 1'b1;
                addr_sel = 1'b1;
                mem_we   = wr_q;
                if (mem_ready) begin
                    if (wr_q) begin
                        retire = 1'b1;
                    end else begin
                        mdr_we  = rd_q;
                        state_d = S_EXEC;
                    end
                end else if (timeout) begin
                    err_d   = 2'b01;
                    state_d = S_HALT;
                end else begin
                    wcnt_d = wcnt_q + WCW'(1);
                end
            end
            S_EXEC: begin
                acc_we = accw_q;
                if (jmp_q || (br_q && acc_zero)) begin
                    pc_we  = 1'b1;
                    pc_src = 1'b1;
                end
                retire = 1'b1;
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: state_d = S_HALT;
        endcase

        // run is only looked at here, on the boundary between instructions
        if (retire) begin
            ret_d   = ret_q + CNT_W'(1);
            state_d = run ? S_FETCH : S_IDLE;
        end
    end

    assign state   = state_q;
    assign halted  = (state_q == S_HALT);
    assign err     = err_q;
    assign retired = ret_q;

endmodule

// File: tb/tb_seq_ctrl.sv
// Bench for seq_ctrl: table of reactive-memory instruction runs, hand-written
// corner sequences, and random instruction streams against a cycle script.
module tb_seq_ctrl;

    localparam int TO = 4;
    localparam int CW = 4;

    localparam logic [7:0] O_REQ = 8'h80;
    localparam logic [7:0] O_WE  = 8'h40;
    localparam logic [7:0] O_AS  = 8'h20;
    localparam logic [7:0] O_IR  = 8'h10;
    localparam logic [7:0] O_MDR = 8'h08;
    localparam logic [7:0] O_PC  = 8'h04;
    localparam logic [7:0] O_SRC = 8'h02;
    localparam logic [7:0] O_ACC = 8'h01;

    logic          clk = 1'b0;
    logic          rst;
    logic          run;
    logic [3:0]    opc;
    logic          dec_jump, dec_branch, dec_memread, dec_memwrite, dec_accwrite;
    logic          acc_zero;
    logic          mem_ready;
    logic          mem_req, mem_we, addr_sel, ir_we, mdr_we, pc_we, pc_src, acc_we;
    logic [2:0]    state;
    logic          halted;
    logic [1:0]    err;
    logic [CW-1:0] retired;

    always #5 clk = ~clk;

    seq_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .run(run), .opc(opc),
        .dec_jump(dec_jump), .dec_branch(dec_branch),
        .dec_memread(dec_memread), .dec_memwrite(dec_memwrite),
        .dec_accwrite(dec_accwrite), .acc_zero(acc_zero),
        .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we),
        .addr_sel(addr_sel), .ir_we(ir_we), .mdr_we(mdr_we),
        .pc_we(pc_we), .pc_src(pc_src), .acc_we(acc_we),
        .state(state), .halted(halted), .err(err), .retired(retired)
    );

    typedef struct {
        logic [3:0] opc;
        logic j, b, r, w, a;
    } ins_t;

    typedef struct {
        int k; int fd; int md; logic az;
        int lat; int acc; int mdr; int pc; int tk;
    } vec_t;

    ins_t isa[8];
    vec_t vt[10];
    int   errs = 0;
    int   checks = 0;
    int   mret = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] outs();
        return {mem_req, mem_we, addr_sel, ir_we, mdr_we, pc_we, pc_src, acc_we};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic step(input logic [7:0] eo, input logic [2:0] es, input string nm);
        #1;
        chk(nm, {29'd0, state}, {29'd0, es});
        chk({nm, "_outs"}, {24'd0, outs()}, {24'd0, eo});
        tick();
    endtask

    task automatic set_ins(input int k);
        opc          = isa[k].opc;
        dec_jump     = isa[k].j;
        dec_branch   = isa[k].b;
        dec_memread  = isa[k].r;
        dec_memwrite = isa[k].w;
        dec_accwrite = isa[k].a;
    endtask

    task automatic do_reset();
        rst = 1'b1; run = 1'b0; mem_ready = 1'b0; acc_zero = 1'b0;
        set_ins(0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        mret = 0;
    endtask

    task automatic start();
        run = 1'b1;
        step(8'h00, 3'd0, "start");
    endtask

    task automatic retire_chk(input string nm);
        mret = (mret + 1) % (1 << CW);
        chk(nm, {28'd0, retired}, mret);
    endtask

    // Reactive memory: ready after fd waits on the first request, md on the second
    task automatic apply(input int idx);
        int reqn = 0, w = 0, lat = 0;
        int nacc = 0, nmdr = 0, npc = 0, ntk = 0;
        logic q, rdy;
        logic [CW-1:0] r0;
        bit done = 0;
        vec_t v = vt[idx];
        r0 = retired;
        set_ins(v.k);
        acc_zero = v.az;
        run = 1'b1;
        for (int c = 0; c < 40 && !done; c++) begin
            mem_ready = mem_req && (w == ((reqn == 0) ? v.fd : v.md));
            #1;
            lat++;
            nacc += int'(acc_we);
            nmdr += int'(mdr_we);
            npc  += int'(pc_we);
            ntk  += int'(pc_we && pc_src);
            q = mem_req;
            rdy = mem_ready;
            tick();
            if (q) begin
                if (rdy) begin reqn++; w = 0; end
                else w++;
            end
            if (retired != r0) done = 1;
        end
        chk($sformatf("tbl%0d_lat", idx), lat, v.lat);
        chk($sformatf("tbl%0d_acc", idx), nacc, v.acc);
        chk($sformatf("tbl%0d_mdr", idx), nmdr, v.mdr);
        chk($sformatf("tbl%0d_pc", idx), npc, v.pc);
        chk($sformatf("tbl%0d_tk", idx), ntk, v.tk);
        retire_chk($sformatf("tbl%0d_ret", idx));
    endtask

    // Scripted instruction: starts and ends in FETCH
    task automatic rnd_instr(input int k, input int fd, input int md,
                             input logic az, input logic ra);
        logic [7:0] mo;
        bit tk;
        set_ins(k);
        acc_zero = az;
        for (int i = 0; i < fd; i++) begin
            mem_ready = 1'b0; run = 1'($urandom);
            step(O_REQ, 3'd1, "fetch_wait");
        end
        mem_ready = 1'b1; run = 1'($urandom);
        step(O_REQ | O_IR | O_PC, 3'd1, "fetch_rdy");
        mem_ready = 1'($urandom);
        step(8'h00, 3'd2, "decode");
        if (isa[k].r || isa[k].w) begin
            mo = O_REQ | O_AS | (isa[k].w ? O_WE : 8'h00);
            for (int i = 0; i < md; i++) begin
                mem_ready = 1'b0; run = 1'($urandom);
                step(mo, 3'd3, "mem_wait");
            end
            mem_ready = 1'b1;
            if (isa[k].w) begin
                run = ra;
                step(mo, 3'd3, "mem_wr");
                retire_chk("ret_save");
            end else begin
                run = 1'($urandom);
                step(mo | O_MDR, 3'd3, "mem_rd");
            end
        end
        if (!isa[k].w) begin
            tk = isa[k].j || (isa[k].b && az);
            mem_ready = 1'($urandom);
            run = ra;
            step((isa[k].a ? O_ACC : 8'h00) | (tk ? (O_PC | O_SRC) : 8'h00),
                 3'd4, "exec");
            retire_chk("ret_exec");
        end
        if (!ra) begin
            repeat ($urandom_range(0, 2)) begin
                run = 1'b0;
                step(8'h00, 3'd0, "idle");
            end
            run = 1'b1;
            step(8'h00, 3'd0, "idle_go");
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int ill[3];
        isa[0] = '{4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        isa[1] = '{4'b0001, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        isa[2] = '{4'b0010, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        isa[3] = '{4'b0011, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        isa[4] = '{4'b0100, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        isa[5] = '{4'b0101, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        isa[6] = '{4'b1110, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        isa[7] = '{4'b1111, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

        //         k  fd md az    lat acc mdr pc tk
        vt[0] = '{4, 0, 0, 1'b0,  3, 1, 0, 1, 0};
        vt[1] = '{3, 2, 2, 1'b0,  8, 1, 1, 1, 0};
        vt[2] = '{2, 0, 0, 1'b0,  3, 0, 0, 1, 0};
        vt[3] = '{2, 1, 3, 1'b1,  7, 0, 0, 1, 0};
        vt[4] = '{7, 0, 0, 1'b1,  4, 0, 1, 2, 1};
        vt[5] = '{7, 0, 0, 1'b0,  4, 0, 1, 1, 0};
        vt[6] = '{6, 1, 0, 1'b0,  5, 0, 1, 2, 1};
        vt[7] = '{0, 0, 0, 1'b1,  3, 0, 0, 1, 0};
        vt[8] = '{1, 3, 3, 1'b0, 10, 1, 1, 1, 0};
        vt[9] = '{5, 0, 0, 1'b0,  3, 1, 0, 1, 0};

        rst = 1'b1; run = 1'b0; mem_ready = 1'b0; acc_zero = 1'b0;
        set_ins(0);
        #1;
        chk("reset_all", {14'd0, state, outs(), halted, err, retired}, 32'd0);

        // LOADI with zero-wait memory, acc_we in the third cycle
        do_reset();
        start();
        rnd_instr(4, 0, 0, 1'b0, 1'b1);

        do_reset();
        start();
        for (int i = 0; i < 10; i++) apply(i);

        // Fetch timeout
        do_reset();
        set_ins(0);
        run = 1'b1;
        step(8'h00, 3'd0, "to_idle");
        for (int i = 0; i < TO; i++) step(O_REQ, 3'd1, "to_wait");
        #1;
        chk("to_halt", {28'd0, state, halted}, {28'd0, 3'd5, 1'b1});
        chk("to_err", {30'd0, err}, 32'd1);
        chk("to_req", {31'd0, mem_req}, 32'd0);
        for (int i = 0; i < 5; i++) begin
            run = ~run;
            mem_ready = 1'($urandom);
            step(8'h00, 3'd5, "halt_hold");
        end
        chk("halt_sticky", {27'd0, halted, err, 2'b00}, {27'd0, 1'b1, 2'b01, 2'b00});
        chk("halt_ret", {28'd0, retired}, 32'd0);

        // Timeout in MEM, after one retired NOP
        do_reset();
        start();
        rnd_instr(0, 0, 0, 1'b0, 1'b1);
        set_ins(3);
        mem_ready = 1'b1;
        step(O_REQ | O_IR | O_PC, 3'd1, "tm_fetch");
        mem_ready = 1'b0;
        step(8'h00, 3'd2, "tm_dec");
        for (int i = 0; i < TO; i++) step(O_REQ | O_AS, 3'd3, "tm_wait");
        #1;
        chk("tm_state", {29'd0, state}, 32'd5);
        chk("tm_err", {30'd0, err}, 32'd1);
        chk("tm_ret", {28'd0, retired}, 32'd1);

        // Illegal opcodes
        ill[0] = 4'b0110; ill[1] = 4'b0111; ill[2] = 4'b1101;
        for (int i = 0; i < 3; i++) begin
            do_reset();
            start();
            set_ins(3);
            opc = 4'(ill[i]);
            mem_ready = 1'b1;
            step(O_REQ | O_IR | O_PC, 3'd1, "ill_fetch");
            step(8'h00, 3'd2, "ill_dec");
            #1;
            chk("ill_state", {29'd0, state}, 32'd5);
            chk("ill_err", {30'd0, err}, 32'd2);
            chk("ill_ret", {28'd0, retired}, 32'd0);
            tick();
        end

        // Asynchronous reset in the middle of a MEM wait
        do_reset();
        start();
        rnd_instr(0, 0, 0, 1'b0, 1'b1);
        set_ins(3);
        mem_ready = 1'b1;
        step(O_REQ | O_IR | O_PC, 3'd1, "ar_fetch");
        mem_ready = 1'b0;
        step(8'h00, 3'd2, "ar_dec");
        step(O_REQ | O_AS, 3'd3, "ar_mem");
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst", {14'd0, state, outs(), halted, err, retired}, 32'd0);
        tick();
        rst = 1'b0;
        mret = 0;

        // Counter wrap with 17 NOPs
        do_reset();
        start();
        for (int i = 0; i < 17; i++) rnd_instr(0, 0, 0, 1'b0, 1'b1);
        chk("wrap", {28'd0, retired}, 32'd1);

        // run=0 during EXEC parks in IDLE
        rnd_instr(4, 0, 0, 1'b0, 1'b0);

        // Random instruction stream
        do_reset();
        start();
        for (int n = 0; n < 60; n++) begin
            rnd_instr($urandom_range(0, 7), $urandom_range(0, TO - 1),
                      $urandom_range(0, TO - 1), 1'($urandom), 1'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
